ppl_fetch_ctl: RTL

Instruction-fetch controller between the fetch PC register and the decode stage.
- Computes the next PC and the load enable for the fetch PC register.
- Runs a request/grant/response handshake with instruction memory.
- Buffers fetched instructions in a small queue, so decode stalls do not drop fetches.
- Branch/jump redirects from later stages flush the queue and discard the in-flight fetch.

---
 rtl/ppl_fetch_ctl_if.sv | 28 ++
 rtl/ppl_fetch_ctl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ppl_fetch_ctl_if.sv
// Fetch-stage bundle: fetch PC register link, redirect, instruction memory
// handshake and the decode-side instruction stream.
interface ppl_fetch_ctl_if;
    logic [31:0] pcF;
    logic [31:0] pcNext;
    logic        pcContinue;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        stallD;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;

    modport master (
        input  pcF, redirect, redirectPc, imemGnt, imemRvalid, imemRdata, stallD,
        output pcNext, pcContinue, imemReq, imemAddr, validD, instrD, pcD
    );

    modport slave (
        output pcF, redirect, redirectPc, imemGnt, imemRvalid, imemRdata, stallD,
        input  pcNext, pcContinue, imemReq, imemAddr, validD, instrD, pcD
    );
endinterface

// File: rtl/ppl_fetch_ctl.sv
// Instruction-fetch controller: next-PC generation, imem request/grant/response
// handshake and a small instruction queue towards decode.
//
// state | meaning
// BOOT  | first cycle after reset, step PC from reset vector to 0
// IDLE  | no fetch outstanding, waiting for a free queue slot
// REQ   | request presented, PC held until grant
// WAIT  | granted, waiting for the response
// DROP  | granted fetch was redirected away, swallow its response
module ppl_fetch_ctl #(
    parameter int          QDEPTH = 2,
    parameter logic [31:0] NOP    = 32'h00000000
) (
    input  logic clk,
    input  logic reset,
    ppl_fetch_ctl_if.master bus
);
    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {BOOT, IDLE, REQ, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   instr_mem_q [QDEPTH];
    logic [31:0]   pc_mem_q    [QDEPTH];

    logic        valid;
    logic        push;
    logic        pop;
    logic        pc_continue;
    logic        imem_req;
    logic [31:0] pc_next;

    assign valid = (count_q != '0);
    assign pop   = valid && !bus.stallD && !bus.redirect;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        req_pc_d    = req_pc_q;
        push        = 1'b0;
        pc_continue = 1'b0;
        imem_req    = 1'b0;
        pc_next     = bus.pcF + 32'd4;

        case (state_q)
            BOOT: begin
                pc_continue = 1'b1;
                state_d     = IDLE;
            end
            IDLE: begin
                if (int'(count_q) - int'(pop) < QDEPTH) state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (bus.imemGnt) begin
                    pc_continue = 1'b1;
                    req_pc_d    = bus.pcF;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus.imemRvalid) begin
                    push = 1'b1;
                    // the slot this response lands in was reserved on entry to REQ
                    if (int'(count_q) + 1 - int'(pop) < QDEPTH) state_d = REQ;
                    else                                       state_d = IDLE;
                end
            end
            DROP: begin
                if (bus.imemRvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            pc_continue = 1'b1;
            pc_next     = bus.redirectPc;
            push        = 1'b0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            case (state_q)
                REQ:     state_d = bus.imemGnt    ? DROP : IDLE;
                WAIT:    state_d = bus.imemRvalid ? IDLE : DROP;
                DROP:    state_d = bus.imemRvalid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            req_pc_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                instr_mem_q[i] <= NOP;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            req_pc_q <= req_pc_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= bus.imemRdata;
                pc_mem_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

    // BOOT is the reset state, so gate its PC load while reset is held
    assign bus.pcNext     = pc_next;
    assign bus.pcContinue = pc_continue & reset;
    assign bus.imemReq    = imem_req & reset;
    assign bus.imemAddr   = bus.pcF;
    assign bus.validD     = valid;
    assign bus.instrD     = valid ? instr_mem_q[rd_ptr_q] : NOP;
    assign bus.pcD        = valid ? pc_mem_q[rd_ptr_q] : 32'd0;
endmodule
